// File: rtl/uart_rx_frame_ctrl.sv
// Frame collector: operand A, operand B (little-endian bytes), opcode -> committed outputs, Enter_ALU on commit,
// trigger WAIT_FOR_REGISTER_DELAY cycles later; no backpressure, bytes arriving while the delay runs are dropped as overrun.
module uart_rx_frame_ctrl #(
  parameter int DATA_WIDTH              = 16,
  parameter int WAIT_FOR_REGISTER_DELAY = 10,
  parameter int TIMEOUT_CYCLES          = 1000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_ready,
  input  logic [7:0]            rx_data,
  output logic [DATA_WIDTH-1:0] operand_a,
  output logic [DATA_WIDTH-1:0] operand_b,
  output logic [7:0]            opcode,
  output logic                  Enter_ALU,
  output logic                  trigger,
  output logic                  frame_error,
  output logic                  overrun,
  output logic [3:0]            LED
);

  localparam int NB  = DATA_WIDTH / 8;
  localparam int CW  = (NB > 1) ? $clog2(NB) : 1;
  localparam int DCW = (WAIT_FOR_REGISTER_DELAY > 1) ? $clog2(WAIT_FOR_REGISTER_DELAY + 1) : 1;
  localparam logic [CW-1:0]  LAST_BYTE = CW'(NB - 1);
  localparam logic [DCW-1:0] DLY_END   = DCW'(WAIT_FOR_REGISTER_DELAY);
  localparam logic [31:0]    TMO_END   = 32'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_RX_A  = 3'd0,
    S_RX_B  = 3'd1,
    S_RX_OP = 3'd2,
    S_DELAY = 3'd3,
    S_TRIG  = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         byte_cnt_q, byte_cnt_d;
  logic [DCW-1:0]        dly_q, dly_d;
  logic [31:0]           tmo_q, tmo_d;
  logic [DATA_WIDTH-1:0] shadow_a_q, shadow_a_d, shadow_b_q, shadow_b_d;
  logic [DATA_WIDTH-1:0] operand_a_q, operand_a_d, operand_b_q, operand_b_d;
  logic [7:0]            opcode_q, opcode_d;
  logic                  enter_q, enter_d, frame_error_q, frame_error_d;
  logic                  overrun_q, overrun_d, err_q, err_d, rx_ready_q, rx_ready_d;
  logic                  byte_evt, partial, commit;

  always_comb begin
    state_d       = state_q;
    byte_cnt_d    = byte_cnt_q;
    dly_d         = dly_q;
    tmo_d         = '0;
    shadow_a_d    = shadow_a_q;
    shadow_b_d    = shadow_b_q;
    operand_a_d   = operand_a_q;
    operand_b_d   = operand_b_q;
    opcode_d      = opcode_q;
    enter_d       = 1'b0;
    frame_error_d = 1'b0;
    overrun_d     = 1'b0;
    err_d         = err_q;
    commit        = 1'b0;
    rx_ready_d    = rx_ready;
    byte_evt      = rx_ready & ~rx_ready_q;
    partial       = ((state_q == S_RX_A) && (byte_cnt_q != '0)) ||
                    (state_q == S_RX_B) || (state_q == S_RX_OP);

    case (state_q)
      S_RX_A, S_RX_B: begin
        if (byte_evt) begin
          for (int i = 0; i < NB; i++) begin
            if (byte_cnt_q == CW'(i)) begin
              if (state_q == S_RX_A) shadow_a_d[i*8 +: 8] = rx_data;
              else                   shadow_b_d[i*8 +: 8] = rx_data;
            end
          end
          if (byte_cnt_q == LAST_BYTE) begin
            byte_cnt_d = '0;
            state_d    = (state_q == S_RX_A) ? S_RX_B : S_RX_OP;
          end else begin
            byte_cnt_d = byte_cnt_q + CW'(1);
          end
        end
      end
      S_RX_OP: begin
        if (byte_evt) begin
          opcode_d    = rx_data;
          operand_a_d = shadow_a_q;
          operand_b_d = shadow_b_q;
          enter_d     = 1'b1;
          commit      = 1'b1;
          dly_d       = DCW'(1);
          state_d     = S_DELAY;
        end
      end
      S_DELAY: begin
        overrun_d = byte_evt;
        if (dly_q == DLY_END) state_d = S_TRIG;
        else                  dly_d   = dly_q + DCW'(1);
      end
      S_TRIG: begin
        overrun_d = byte_evt;
        state_d   = S_RX_A;
      end
      default: state_d = S_RX_A;
    endcase

    // A byte arriving on the terminal-count cycle keeps the frame alive.
    if ((TIMEOUT_CYCLES != 0) && partial && !byte_evt) begin
      if (tmo_q == TMO_END) begin
        state_d       = S_RX_A;
        byte_cnt_d    = '0;
        frame_error_d = 1'b1;
      end else begin
        tmo_d = tmo_q + 32'd1;
      end
    end

    if (frame_error_d || overrun_d) err_d = 1'b1;
    else if (commit)                err_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_RX_A;
      byte_cnt_q    <= '0;
      dly_q         <= '0;
      tmo_q         <= '0;
      shadow_a_q    <= '0;
      shadow_b_q    <= '0;
      operand_a_q   <= '0;
      operand_b_q   <= '0;
      opcode_q      <= '0;
      enter_q       <= 1'b0;
      frame_error_q <= 1'b0;
      overrun_q     <= 1'b0;
      err_q         <= 1'b0;
      rx_ready_q    <= 1'b1;
    end else begin
      state_q       <= state_d;
      byte_cnt_q    <= byte_cnt_d;
      dly_q         <= dly_d;
      tmo_q         <= tmo_d;
      shadow_a_q    <= shadow_a_d;
      shadow_b_q    <= shadow_b_d;
      operand_a_q   <= operand_a_d;
      operand_b_q   <= operand_b_d;
      opcode_q      <= opcode_d;
      enter_q       <= enter_d;
      frame_error_q <= frame_error_d;
      overrun_q     <= overrun_d;
      err_q         <= err_d;
      rx_ready_q    <= rx_ready_d;
    end
  end

  assign operand_a   = operand_a_q;
  assign operand_b   = operand_b_q;
  assign opcode      = opcode_q;
  assign Enter_ALU   = enter_q;
  assign trigger     = (state_q == S_TRIG);
  assign frame_error = frame_error_q;
  assign overrun     = overrun_q;
  assign LED         = {err_q, state_q};

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed bench for uart_rx_frame_ctrl: a 16-bit instance (delay 3, timeout 50) and a 32-bit instance (timeout off).
module tb_uart_rx_frame_ctrl;
  localparam int D = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx16_ready = 1'b0, rx32_ready = 1'b0;
  logic [7:0]  rx16_data = 8'h00, rx32_data = 8'h00;
  logic [15:0] a16, b16;
  logic [31:0] a32, b32;
  logic [7:0]  op16, op32;
  logic        ent16, trg16, fe16, ov16, ent32, trg32, fe32, ov32;
  logic [3:0]  led16, led32;

  uart_rx_frame_ctrl #(.DATA_WIDTH(16), .WAIT_FOR_REGISTER_DELAY(D), .TIMEOUT_CYCLES(50)) u16 (
    .clk(clk), .reset(reset), .rx_ready(rx16_ready), .rx_data(rx16_data),
    .operand_a(a16), .operand_b(b16), .opcode(op16), .Enter_ALU(ent16), .trigger(trg16),
    .frame_error(fe16), .overrun(ov16), .LED(led16));

  uart_rx_frame_ctrl #(.DATA_WIDTH(32), .WAIT_FOR_REGISTER_DELAY(D), .TIMEOUT_CYCLES(0)) u32 (
    .clk(clk), .reset(reset), .rx_ready(rx32_ready), .rx_data(rx32_data),
    .operand_a(a32), .operand_b(b32), .opcode(op32), .Enter_ALU(ent32), .trigger(trg32),
    .frame_error(fe32), .overrun(ov32), .LED(led32));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [7:0]  op;
    int          enter_cyc;
  } frame_t;

  frame_t sb16[$], sb32[$];
  int     trig16[$], trig32[$];
  int     vectors = 0, miscompares = 0, fe_cnt = 0, ov_cnt = 0;
  logic [15:0] last_a16 = '0, last_b16 = '0;
  logic [7:0]  last_op16 = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output-side scoreboard: frames on Enter_ALU, trigger timing against the commit cycle.
  always @(negedge clk) begin
    frame_t f;
    if (!reset) begin
      if (ent16) begin
        chk("enter16_expected", 64'(sb16.size() != 0), 64'(1));
        if (sb16.size() != 0) begin
          f = sb16.pop_front();
          chk("a16", 64'(a16), 64'(f.a[15:0]));
          chk("b16", 64'(b16), 64'(f.b[15:0]));
          chk("op16", 64'(op16), 64'(f.op));
          chk("enter16_cyc", 64'(cyc), 64'(f.enter_cyc));
          trig16.push_back(f.enter_cyc + D);
        end
      end
      if (trg16) begin
        chk("trig16_expected", 64'(trig16.size() != 0), 64'(1));
        if (trig16.size() != 0) chk("trig16_cyc", 64'(cyc), 64'(trig16.pop_front()));
      end
      if (ent32) begin
        chk("enter32_expected", 64'(sb32.size() != 0), 64'(1));
        if (sb32.size() != 0) begin
          f = sb32.pop_front();
          chk("a32", 64'(a32), 64'(f.a));
          chk("b32", 64'(b32), 64'(f.b));
          chk("op32", 64'(op32), 64'(f.op));
          chk("enter32_cyc", 64'(cyc), 64'(f.enter_cyc));
          trig32.push_back(f.enter_cyc + D);
        end
      end
      if (trg32) begin
        chk("trig32_expected", 64'(trig32.size() != 0), 64'(1));
        if (trig32.size() != 0) chk("trig32_cyc", 64'(cyc), 64'(trig32.pop_front()));
      end
      if (fe16) fe_cnt++;
      if (ov16) ov_cnt++;
    end
  end

  task automatic drive16(input logic [7:0] b, output int evt_cyc);
    @(posedge clk); #1;
    rx16_data = b; rx16_ready = 1'b1; evt_cyc = cyc;
    @(posedge clk); #1;
    rx16_ready = 1'b0;
  endtask

  task automatic drive32(input logic [7:0] b, output int evt_cyc);
    @(posedge clk); #1;
    rx32_data = b; rx32_ready = 1'b1; evt_cyc = cyc;
    @(posedge clk); #1;
    rx32_ready = 1'b0;
  endtask

  task automatic frame16(input logic [15:0] a, input logic [15:0] b, input logic [7:0] op);
    int e;
    drive16(a[7:0], e); drive16(a[15:8], e);
    drive16(b[7:0], e); drive16(b[15:8], e);
    drive16(op, e);
    sb16.push_back('{a: {16'h0, a}, b: {16'h0, b}, op: op, enter_cyc: e + 1});
    last_a16 = a; last_b16 = b; last_op16 = op;
  endtask

  task automatic frame32(input logic [31:0] a, input logic [31:0] b, input logic [7:0] op);
    int e;
    for (int i = 0; i < 4; i++) drive32(a[i*8 +: 8], e);
    for (int i = 0; i < 4; i++) drive32(b[i*8 +: 8], e);
    drive32(op, e);
    sb32.push_back('{a: a, b: b, op: op, enter_cyc: e + 1});
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (sb16.size() + trig16.size() + sb32.size() + trig32.size() == 0) break;
    end
    chk(tag, 64'(sb16.size() + trig16.size() + sb32.size() + trig32.size()), 64'(0));
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    int e, fe0, ov0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_a16", 64'(a16), 64'(0));
    chk("rst_b16", 64'(b16), 64'(0));
    chk("rst_op16", 64'(op16), 64'(0));
    chk("rst_pulses16", 64'({ent16, trg16, fe16, ov16}), 64'(0));
    chk("rst_led16", 64'(led16), 64'(0));

    // Basic 16-bit frame with trigger latency.
    frame16(16'h1234, 16'h5678, 8'h02);
    wait_idle("t1_idle");
    chk("t1_led", 64'(led16), 64'(0));

    // Held-high rx_ready counts once.
    @(posedge clk); #1 rx16_data = 8'hFE; rx16_ready = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("t2_byte_cnt", 64'(u16.byte_cnt_q), 64'(1));
    chk("t2_state", 64'(led16[2:0]), 64'(0));
    @(posedge clk); #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("t2_rst_held_cnt", 64'(u16.byte_cnt_q), 64'(0));
    chk("t2_rst_held_led", 64'(led16), 64'(0));
    #1 rx16_ready = 1'b0;
    frame16(16'h1234, 16'h5678, 8'h02);
    wait_idle("t2_idle");

    // Timeout on a partial frame.
    fe0 = fe_cnt;
    drive16(8'h34, e); drive16(8'h12, e); drive16(8'h78, e);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (fe_cnt != fe0) break;
    end
    repeat (5) @(negedge clk);
    chk("t3_fe_once", 64'(fe_cnt - fe0), 64'(1));
    chk("t3_led", 64'(led16), 64'(4'b1000));
    chk("t3_a_kept", 64'(a16), 64'(last_a16));
    chk("t3_b_kept", 64'(b16), 64'(last_b16));
    chk("t3_op_kept", 64'(op16), 64'(last_op16));
    frame16(16'h00AA, 16'h00BB, 8'h05);
    wait_idle("t3_idle");
    chk("t3_led_clr", 64'(led16), 64'(0));

    // Overrun during the delay window.
    ov0 = ov_cnt;
    frame16(16'hBEEF, 16'hCAFE, 8'h11);
    drive16(8'hC3, e);
    wait_idle("t4_idle");
    chk("t4_ov_once", 64'(ov_cnt - ov0), 64'(1));
    chk("t4_led", 64'(led16), 64'(4'b1000));
    chk("t4_cnt_clean", 64'(u16.byte_cnt_q), 64'(0));

    // Reset mid-frame, then a clean frame.
    drive16(8'h01, e); drive16(8'h02, e); drive16(8'h03, e);
    pulse_reset();
    @(negedge clk);
    chk("t5_a", 64'(a16), 64'(0));
    chk("t5_b", 64'(b16), 64'(0));
    chk("t5_op", 64'(op16), 64'(0));
    chk("t5_led", 64'(led16), 64'(0));
    frame16(16'h4321, 16'h8765, 8'h09);
    wait_idle("t5_idle");

    // Reset during the delay: no trigger may follow.
    frame16(16'h0F0F, 16'hF0F0, 8'h33);
    @(negedge clk);
    pulse_reset();
    trig16.delete();
    repeat (10) @(negedge clk);
    chk("t5b_a", 64'(a16), 64'(0));
    chk("t5b_state", 64'(led16), 64'(0));

    // 32-bit operands.
    frame32(32'h12345678, 32'hDEADBEEF, 8'h0F);
    wait_idle("t6_idle");
    chk("t6_led", 64'(led32), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_rx_frame_ctrl.md
Name: uart_rx_frame_ctrl

Overview:
Parametrised successor to the byte-to-ALU receive controller. Collects a framed command from the UART receiver: operand A, operand B (each DATA_WIDTH bits, little-endian bytes), then one opcode byte. Commits all three to registered outputs and issues a delayed one-cycle trigger to the ALU. Adds a timeout that discards partial frames, overrun detection, and a status LED code.

Parameters:
DATA_WIDTH, 16, operand width in bits; a multiple of 8, from 8 to 64.
WAIT_FOR_REGISTER_DELAY, 10, cycles from commit to the trigger pulse; must be 1 or more.
TIMEOUT_CYCLES, 1000000, idle cycles allowed inside a partial frame before abort; 0 disables the timeout.

Ports:
clk  in  1  system clock.
reset  in  1  synchronous, active-high reset.
rx_ready  in  1  UART byte-valid level; one byte per rising edge, may stay high for many cycles.
rx_data  in  8  received byte; valid on the rx_ready rising-edge cycle.
operand_a  out  DATA_WIDTH  committed operand A.
operand_b  out  DATA_WIDTH  committed operand B.
opcode  out  8  committed opcode byte.
Enter_ALU  out  1  one-cycle pulse on the commit cycle.
trigger  out  1  one-cycle pulse WAIT_FOR_REGISTER_DELAY cycles after commit.
frame_error  out  1  one-cycle pulse on timeout abort.
overrun  out  1  one-cycle pulse when a byte arrives during S_DELAY or S_TRIG.
LED  out  4  LED[2:0] state code, LED[3] sticky error flag.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high.
- Outputs at reset: operand_a, operand_b, opcode = 0. Enter_ALU, trigger, frame_error, overrun = 0. LED = 4'b0000. State is S_RX_A. Byte counter and timeout counter = 0.
- Edge detect:
  - rx_ready_q is a registered copy of rx_ready. It resets to 1, so a level held high through reset is not taken as a byte.
  - byte_evt = rx_ready & ~rx_ready_q. rx_data is captured in the byte_evt cycle.
- States and LED[2:0] codes:
  - S_RX_A = 0, S_RX_B = 1, S_RX_OP = 2, S_DELAY = 3, S_TRIG = 4.
- S_RX_A / S_RX_B:
  - Each byte_evt writes rx_data into byte slot byte_cnt of a shadow register; slot 0 is the LSB.
  - byte_cnt wraps at DATA_WIDTH/8 - 1, and the state advances on that byte.
- S_RX_OP:
  - byte_evt captures the opcode into the shadow register and moves to S_DELAY.
  - On the same edge all shadows copy to operand_a, operand_b and opcode. Outputs are visible, and Enter_ALU=1, in the cycle after that byte_evt.
- Committed outputs change only at commit. Partial frames never disturb them.
- S_DELAY:
  - The delay counter counts WAIT_FOR_REGISTER_DELAY cycles, with the commit cycle as count 1.
  - It then enters S_TRIG. trigger=1 for exactly that one cycle, then the state returns to S_RX_A.
  - Latency: opcode byte_evt at cycle N → Enter_ALU at N+1 → trigger at N+1+WAIT_FOR_REGISTER_DELAY.
- Overrun: a byte_evt in S_DELAY or S_TRIG is dropped and overrun pulses in the next cycle. The trigger schedule is unaffected.
- Timeout:
  - A frame is partial when the state is S_RX_A with byte_cnt>0, or S_RX_B, or S_RX_OP.
  - While partial, the timeout counter increments each cycle without byte_evt and clears on byte_evt.
  - When it reaches TIMEOUT_CYCLES, the next cycle has: state=S_RX_A, byte_cnt=0, counter=0, frame_error=1 for one cycle.
  - A byte_evt in the same cycle as the terminal count wins: the byte is accepted and no abort occurs.
- LED[3]: set on frame_error or overrun; cleared at the next commit. A set and a clear in the same cycle leaves it set.
- Reset mid-frame or mid-delay: immediate return to reset values. No trigger is issued for the interrupted frame.
- DATA_WIDTH=8: each operand is one byte; frame length is 3 bytes.

Test Plan:
1. DATA_WIDTH=16, DELAY=3. Bytes 34,12,78,56,02 (hex) on separate rx_ready edges, last edge at cycle N → operand_a=16'h1234, operand_b=16'h5678, opcode=8'h02 and Enter_ALU at N+1; trigger high only at N+4; LED=4'b0000 afterwards.
2. rx_ready held high for 20 cycles after one byte FE → exactly one byte accepted (byte_cnt=1, state S_RX_A); a held-high rx_ready across reset deassertion → no byte accepted.
3. TIMEOUT_CYCLES=50. Send 34,12,78, then idle → frame_error pulse exactly once, LED[3]=1, operands unchanged. A following full frame AA,00,BB,00,05 commits 16'h00AA/16'h00BB/8'h05 and clears LED[3].
4. A byte edge during S_DELAY → overrun pulse, LED[3]=1, trigger still at N+1+DELAY, byte not counted toward the next frame.
5. Assert reset after 3 of 5 bytes → all outputs 0. A fresh 5-byte frame then decodes correctly.
6. DATA_WIDTH=32. Bytes 78,56,34,12,EF,BE,AD,DE,0F → operand_a=32'h12345678, operand_b=32'hDEADBEEF, opcode=8'h0F.
